// File: rtl/b2g_pkg.sv
// b2g_pkg: shared constants and types for the gray-FIFO drain engine.
//   Register map of the binary-to-gray FIFO block, status bit positions,
//   the clear command word, and the drain FSM state type.
package b2g_pkg;

   // FIFO block register addresses used by the engine
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_STAT = 2'd3;

   // Status register bit positions
   localparam int unsigned ST_EMPTY = 0;
   localparam int unsigned ST_FULL  = 1;
   localparam int unsigned ST_OVF   = 2;
   localparam int unsigned ST_UNF   = 3;
   localparam int unsigned ST_CLR   = 4;

   // Written to the status register to flush the FIFO
   localparam logic [7:0] CLR_WORD = 8'h10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      POLL  = 3'd1,
      CHECK = 3'd2,
      WAIT  = 3'd3,
      POP   = 3'd4,
      OUT   = 3'd5,
      CLEAR = 3'd6
   } drain_state_t;

endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational gray-code to binary converter (inverse of bin2gray).
//   gray : input  [DW-1:0]  gray-coded word
//   bin  : output [DW-1:0]  binary word; bin[i] = XOR of gray[DW-1:i]
module gray2bin #(
   parameter int unsigned DW = 8
) (
   input  logic [DW-1:0] gray,
   output logic [DW-1:0] bin
);

   // Running XOR from the MSB downward
   always_comb begin
      logic acc;
      acc = 1'b0;
      bin = '0;
      for (int unsigned i = DW; i > 0; i--) begin
         acc        = acc ^ gray[i-1];
         bin[i-1]   = acc;
      end
   end

endmodule

// File: rtl/gray_drain_engine.sv
// gray_drain_engine: sole bus master of the binary-to-gray FIFO block.
//   Polls the status register, pops gray words while the FIFO is not empty,
//   converts them to binary and presents them on a valid/ready stream.
//   Also issues FIFO clear writes and keeps sticky error flags.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   run                 1 = drain continuously, 0 = stop after current work
//   clr_req             one-cycle pulse requesting a FIFO clear
//   bus_enable/addr/write/read/wdata   registered bus request to the FIFO
//   bus_rdata, bus_resp                FIFO read data (same cycle) and error
//   m_data, m_valid, m_ready           binary output stream
//   ovf_seen, unf_seen, resp_err       sticky flags, cleared only by reset
//   drain_cnt                          words delivered, wrapping
module gray_drain_engine
   import b2g_pkg::*;
#(
   parameter int unsigned DW       = 8,
   parameter int unsigned POLL_GAP = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clr_req,
   output logic             bus_enable,
   output logic [1:0]       bus_addr,
   output logic             bus_write,
   output logic             bus_read,
   output logic [DW-1:0]    bus_wdata,
   input  logic [DW-1:0]    bus_rdata,
   input  logic             bus_resp,
   output logic [DW-1:0]    m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             ovf_seen,
   output logic             unf_seen,
   output logic             resp_err,
   output logic [CNT_W-1:0] drain_cnt
);

   localparam int unsigned GW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;

   drain_state_t  state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          clr_pend_q;
   logic          stat_empty_q;
   logic [DW-1:0] bin_word;

   gray2bin #(.DW(DW)) u_gray2bin (
      .gray (bus_rdata),
      .bin  (bin_word)
   );

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      unique case (state_q)
         IDLE: begin
            if (clr_pend_q)   state_d = CLEAR;
            else if (run)     state_d = POLL;
         end
         POLL:  state_d = CHECK;
         CHECK: begin
            if (clr_pend_q)         state_d = CLEAR;
            else if (!stat_empty_q) state_d = POP;
            else if (POLL_GAP == 0) state_d = run ? POLL : IDLE;
            else begin
               state_d = WAIT;
               gap_d   = GW'(POLL_GAP);
            end
         end
         WAIT: begin
            if (clr_pend_q)       state_d = CLEAR;
            else if (gap_q == '0) state_d = run ? POLL : IDLE;
            else                  gap_d   = gap_q - GW'(1);
         end
         POP: state_d = OUT;
         OUT: begin
            if (m_valid && m_ready) state_d = run ? POLL : IDLE;
         end
         CLEAR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs are registered from the next state so that the request is
   // on the bus for exactly the cycle the FSM spends in POLL/POP/CLEAR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gap_q        <= '0;
         clr_pend_q   <= 1'b0;
         stat_empty_q <= 1'b0;
         bus_enable   <= 1'b0;
         bus_addr     <= '0;
         bus_write    <= 1'b0;
         bus_read     <= 1'b0;
         bus_wdata    <= '0;
         m_data       <= '0;
         m_valid      <= 1'b0;
         ovf_seen     <= 1'b0;
         unf_seen     <= 1'b0;
         resp_err     <= 1'b0;
         drain_cnt    <= '0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;

         bus_enable <= (state_d == POLL) || (state_d == POP) || (state_d == CLEAR);
         bus_read   <= (state_d == POLL) || (state_d == POP);
         bus_write  <= (state_d == CLEAR);
         if (state_d == POP)                           bus_addr <= ADDR_DATA;
         else if (state_d == POLL || state_d == CLEAR) bus_addr <= ADDR_STAT;
         else                                          bus_addr <= '0;
         bus_wdata  <= (state_d == CLEAR) ? DW'(CLR_WORD) : '0;

         // A pulse arriving in the CLEAR cycle itself stays pending
         if (state_q == CLEAR) clr_pend_q <= clr_req;
         else                  clr_pend_q <= clr_pend_q | clr_req;

         if (state_q == POLL) begin
            stat_empty_q <= bus_rdata[ST_EMPTY];
            ovf_seen     <= ovf_seen | bus_rdata[ST_OVF];
            unf_seen     <= unf_seen | bus_rdata[ST_UNF];
         end

         if (bus_enable && bus_resp) resp_err <= 1'b1;

         if (state_q == POP) begin
            m_data  <= bin_word;
            m_valid <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid   <= 1'b0;
            drain_cnt <= drain_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_gray_drain_engine.sv
// tb_gray_drain_engine: scoreboard bench for gray_drain_engine with a
//   behavioural model of the FIFO register block on the bus side.
module tb_gray_drain_engine;

   localparam int unsigned DW       = 8;
   localparam int unsigned POLL_GAP = 4;
   localparam int unsigned CNT_W    = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             run = 1'b0;
   logic             clr_req = 1'b0;
   logic             m_ready = 1'b0;
   logic             bus_enable, bus_write, bus_read;
   logic [1:0]       bus_addr;
   logic [DW-1:0]    bus_wdata;
   logic [DW-1:0]    bus_rdata = '0;
   logic             bus_resp = 1'b0;
   logic [DW-1:0]    m_data;
   logic             m_valid;
   logic             ovf_seen, unf_seen, resp_err;
   logic [CNT_W-1:0] drain_cnt;

   always #5 clk = ~clk;

   gray_drain_engine #(.DW(DW), .POLL_GAP(POLL_GAP), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .clr_req    (clr_req),
      .bus_enable (bus_enable),
      .bus_addr   (bus_addr),
      .bus_write  (bus_write),
      .bus_read   (bus_read),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_resp   (bus_resp),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .ovf_seen   (ovf_seen),
      .unf_seen   (unf_seen),
      .resp_err   (resp_err),
      .drain_cnt  (drain_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- FIFO block model ----------------
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] stat_extra = '0;
   logic          resp_force = 1'b0;

   always @(negedge clk) begin
      bus_rdata = '0;
      bus_resp  = 1'b0;
      if (bus_enable && bus_read) begin
         if (bus_addr == 2'd0 && fifo_q.size() > 0) begin
            bus_rdata = fifo_q[0];
         end else if (bus_addr == 2'd3) begin
            bus_rdata    = stat_extra;
            bus_rdata[0] = (fifo_q.size() == 0);
            bus_resp     = resp_force;
         end
      end
   end

   always @(posedge clk) begin
      if (bus_enable && bus_read && bus_addr == 2'd0 && fifo_q.size() > 0)
         void'(fifo_q.pop_front());
      if (bus_enable && bus_write && bus_addr == 2'd3 && bus_wdata[4])
         fifo_q.delete();
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      logic          wr;
      logic [1:0]    addr;
      logic [DW-1:0] wd;
      int            t;
   } txn_t;

   txn_t          log_q[$];
   logic [DW-1:0] sb_q[$];
   int   cyc = 0, txn_cnt = 0, pop_cnt = 0, poll_cnt = 0, wr_cnt = 0;
   int   prev_poll_t = 0, last_poll_t = 0;
   logic mv_seen = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid) mv_seen = 1'b1;
         if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL stream_unexpected: got %0h expected no word", m_data);
            end else begin
               chk("stream_data", m_data, sb_q.pop_front());
            end
         end
         if (bus_enable) begin
            txn_cnt++;
            log_q.push_back('{bus_write, bus_addr, bus_wdata, cyc});
            chk("bus_rw_onehot", bus_read ^ bus_write, 1);
            chk("bus_addr_legal", (bus_addr == 2'd0 || bus_addr == 2'd3), 1);
            if (bus_read && bus_addr == 2'd0) begin
               pop_cnt++;
               chk("no_pop_while_valid", m_valid, 0);
            end
            if (bus_read && bus_addr == 2'd3) begin
               poll_cnt++;
               prev_poll_t = last_poll_t;
               last_poll_t = cyc;
            end
            if (bus_write) wr_cnt++;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int p0, q0, t0, w0;

      // reset
      #1 rst_n = 1'b0;
      #2;
      chk("reset_bus", {bus_enable, bus_read, bus_write, bus_addr, bus_wdata}, 0);
      chk("reset_out", {m_valid, m_data, drain_cnt, ovf_seen, unf_seen, resp_err}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // drain three words: binaries 00,05,FF stored as gray 00,07,80
      @(posedge clk); #1;
      fifo_q.push_back(8'h00); sb_q.push_back(8'h00);
      fifo_q.push_back(8'h07); sb_q.push_back(8'h05);
      fifo_q.push_back(8'h80); sb_q.push_back(8'hFF);
      run = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 200 && drain_cnt != 3; i++) @(negedge clk);
      chk("drain_cnt_3", drain_cnt, 3);
      chk("pops_3", pop_cnt, 3);
      repeat (30) @(negedge clk);
      chk("poll_spacing", last_poll_t - prev_poll_t, POLL_GAP + 3);

      // empty FIFO: polls continue, no data reads, no output
      p0 = pop_cnt;
      q0 = poll_cnt;
      mv_seen = 1'b0;
      repeat (40) @(negedge clk);
      chk("empty_no_pop", pop_cnt - p0, 0);
      chk("empty_no_valid", mv_seen, 0);
      chk("empty_polling", (poll_cnt - q0) >= 4, 1);

      // sink stall: binary 3C stored as gray 22
      @(posedge clk); #1;
      m_ready = 1'b0;
      p0 = pop_cnt;
      fifo_q.push_back(8'h22);
      sb_q.push_back(8'h3C);
      for (int i = 0; i < 100 && !m_valid; i++) @(negedge clk);
      chk("stall_valid_up", m_valid, 1);
      t0 = txn_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_data", m_data, 8'h3C);
         chk("stall_valid", m_valid, 1);
      end
      chk("stall_one_pop", pop_cnt - p0, 1);
      chk("stall_no_bus", txn_cnt - t0, 0);

      // clear request while the word is still held
      @(posedge clk); #1 clr_req = 1'b1;
      @(posedge clk); #1 clr_req = 1'b0;
      log_q.delete();
      w0 = wr_cnt;
      m_ready = 1'b1;
      for (int i = 0; i < 100 && drain_cnt != 4; i++) @(negedge clk);
      repeat (12) @(negedge clk);
      chk("clr_drain_cnt", drain_cnt, 4);
      chk("clr_one_write", wr_cnt - w0, 1);
      if (log_q.size() >= 3) begin
         chk("clr_first_poll", {log_q[0].wr, log_q[0].addr}, 3'b011);
         chk("clr_write", {log_q[1].wr, log_q[1].addr, log_q[1].wd}, {3'b111, 8'h10});
         chk("clr_then_poll", {log_q[2].wr, log_q[2].addr}, 3'b011);
         chk("clr_idle_gap", log_q[2].t - log_q[1].t, 2);
      end else begin
         total++;
         bad++;
         $display("FAIL clr_sequence: got %0d transactions expected at least 3", log_q.size());
      end

      // sticky status flags and bus error
      chk("flags_clean", {ovf_seen, unf_seen, resp_err}, 3'b000);
      @(posedge clk); #1 stat_extra = 8'h0C;
      q0 = poll_cnt;
      for (int i = 0; i < 60 && poll_cnt == q0; i++) @(negedge clk);
      @(posedge clk); #1 stat_extra = '0;
      q0 = poll_cnt;
      for (int i = 0; i < 60 && poll_cnt < q0 + 2; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("ovf_sticky", ovf_seen, 1);
      chk("unf_sticky", unf_seen, 1);
      chk("resp_still_clean", resp_err, 0);
      @(posedge clk); #1 resp_force = 1'b1;
      q0 = poll_cnt;
      for (int i = 0; i < 60 && poll_cnt == q0; i++) @(negedge clk);
      @(posedge clk); #1 resp_force = 1'b0;
      repeat (3) @(negedge clk);
      chk("resp_err_set", resp_err, 1);

      // asynchronous reset in the middle of a pop
      @(posedge clk); #1 fifo_q.push_back(8'h55);
      for (int i = 0; i < 60 && !(bus_enable && bus_read && bus_addr == 2'd0); i++)
         @(negedge clk);
      chk("pop_before_reset", bus_enable && bus_read && bus_addr == 2'd0, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_bus", {bus_enable, bus_read, bus_write, bus_addr, bus_wdata}, 0);
      chk("async_reset_out", {m_valid, m_data, drain_cnt, ovf_seen, unf_seen, resp_err}, 0);
      run = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      t0 = txn_cnt;
      repeat (10) @(negedge clk);
      chk("post_reset_cnt", drain_cnt, 0);
      chk("post_reset_idle", txn_cnt - t0, 0);
      chk("post_reset_valid", m_valid, 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
